// File: rtl/wave_capture_ctrl_pkg.sv
// wave_capture_pkg: shared states, default sizes and sample format helper for wave_capture_ctrl
package wave_capture_pkg;
   localparam int SAMPLE_W_DEF     = 16;
   localparam int ADDR_W_DEF       = 8;
   localparam int TRIG_TIMEOUT_DEF = 1024;
   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      ACTIVE = 2'd1,
      WAIT   = 2'd2
   } cap_state_t;
   // top byte of a two's complement sample -> offset binary (flip the sign bit)
   function automatic logic [7:0] offset_bin8(input logic [7:0] hi);
      return {~hi[7], hi[6:0]};
   endfunction
endpackage

// File: rtl/wave_capture_ctrl_if.sv
// wave_capture_ctrl_if: sample stream, display handshake and RAM write port of the capture sequencer
interface wave_capture_ctrl_if #(
   parameter int SAMPLE_W = 16,
   parameter int ADDR_W   = 8
);
   logic                new_sample_ready;
   logic [SAMPLE_W-1:0] new_sample_in;
   logic                wave_display_idle;
   logic                write_enable;
   logic [ADDR_W:0]     write_address;
   logic [7:0]          write_sample;
   logic                read_index;
   logic [1:0]          capture_state;
   modport master (
      output new_sample_ready, new_sample_in, wave_display_idle,
      input  write_enable, write_address, write_sample, read_index, capture_state
   );
   modport slave (
      input  new_sample_ready, new_sample_in, wave_display_idle,
      output write_enable, write_address, write_sample, read_index, capture_state
   );
endinterface

// File: rtl/wave_capture_ctrl_zero_cross_detect.sv
// zero_cross_detect: flags a negative-to-non-negative transition on each accepted sample
module zero_cross_detect (
   input  logic clk,
   input  logic reset,
   input  logic i_valid,
   input  logic i_sign,
   output logic o_trig
);
   logic r_prev_neg;
   // only the sign of the previous sample matters for crossing detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_prev_neg <= 1'b0;
      else if (i_valid) r_prev_neg <= i_sign;
   end
   assign o_trig = i_valid & r_prev_neg & ~i_sign;
endmodule

// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl: triggered 256-sample capture into the hidden half of a double-buffered wave RAM
module wave_capture_ctrl
   import wave_capture_pkg::*;
#(
   parameter int SAMPLE_W     = SAMPLE_W_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int TRIG_TIMEOUT = TRIG_TIMEOUT_DEF
) (
   input logic clk,
   input logic reset,
   wave_capture_ctrl_if.slave bus
);
   localparam int TMO_W = $clog2(TRIG_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TRIG_TIMEOUT - 1);

   cap_state_t        r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
   logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
   logic              r_ri, w_ri_nxt;
   logic              r_we, w_we_nxt;
   logic [ADDR_W:0]   r_addr, w_addr_nxt;
   logic [7:0]        r_wsamp, w_wsamp_nxt;
   logic              w_trig, w_write, w_unused;

   zero_cross_detect u_zc (
      .clk     (clk),
      .reset   (reset),
      .i_valid (bus.new_sample_ready),
      .i_sign  (bus.new_sample_in[SAMPLE_W-1]),
      .o_trig  (w_trig)
   );

   assign w_unused = ^bus.new_sample_in[SAMPLE_W-9:0];

   // the illegal encoding 3 falls into the default arm and behaves as ARMED
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tmo_nxt   = r_tmo;
      w_ri_nxt    = r_ri;
      w_write     = 1'b0;
      case (r_state)
         ACTIVE: begin
            w_write = bus.new_sample_ready;
            if (bus.new_sample_ready && (&r_cnt)) w_state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.wave_display_idle) begin
               w_ri_nxt    = ~r_ri;
               w_state_nxt = ARMED;
               w_tmo_nxt   = '0;
            end
         end
         default: begin
            if (bus.new_sample_ready) begin
               if (w_trig || r_tmo == TMO_LAST) begin
                  w_write     = 1'b1;
                  w_state_nxt = ACTIVE;
               end else begin
                  w_tmo_nxt = r_tmo + 1'b1;
               end
            end
         end
      endcase
      w_cnt_nxt   = w_write ? r_cnt + 1'b1 : w_cnt_nxt;
      w_we_nxt    = w_write;
      w_addr_nxt  = w_write ? {~r_ri, r_cnt} : r_addr;
      w_wsamp_nxt = w_write ? offset_bin8(bus.new_sample_in[SAMPLE_W-1 -: 8]) : r_wsamp;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ARMED;
         r_cnt   <= '0;
         r_tmo   <= '0;
         r_ri    <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wsamp <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tmo   <= w_tmo_nxt;
         r_ri    <= w_ri_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_wsamp <= w_wsamp_nxt;
      end
   end

   assign bus.write_enable  = r_we;
   assign bus.write_address = r_addr;
   assign bus.write_sample  = r_wsamp;
   assign bus.read_index    = r_ri;
   assign bus.capture_state = r_state;
endmodule

// File: tb/tb_wave_capture_ctrl.sv
// tb_wave_capture_ctrl: directed scenario checks for wave_capture_ctrl
module tb_wave_capture_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   wave_capture_ctrl_if #(.SAMPLE_W(16), .ADDR_W(8)) bus ();

   wave_capture_ctrl #(.SAMPLE_W(16), .ADDR_W(8), .TRIG_TIMEOUT(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      bus.new_sample_ready = 1'b0;
      bus.new_sample_in = '0;
      bus.wave_display_idle = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // one isolated strobe; returns at the negedge where its registered result is visible
   task automatic strobe(input logic [15:0] s);
      @(negedge clk);
      bus.new_sample_ready = 1'b1;
      bus.new_sample_in = s;
      @(negedge clk);
      bus.new_sample_ready = 1'b0;
   endtask

   // negative lead-in then back-to-back ramp 0..255<<8; ramp sample 0 is the trigger
   task automatic capture_ramp(input logic [8:0] base, input logic [15:0] lead);
      logic [17:0] got, exp;
      strobe(lead);
      for (int i = 0; i <= 256; i++) begin
         @(negedge clk);
         if (i > 0) begin
            got = {bus.write_enable, bus.write_address, bus.write_sample};
            exp = {1'b1, 9'(base + 9'(i - 1)), 8'(i - 1) ^ 8'h80};
            n_total++;
            if (got !== exp) $display("FAIL ramp_write[%0d]: got %h want %h", i - 1, got, exp);
            else n_pass++;
         end
         bus.new_sample_ready = (i < 256);
         bus.new_sample_in = 16'((i & 255) << 8);
      end
      n_total++;
      if (bus.capture_state !== 2'd2) $display("FAIL ramp_wait_state: got %0d want 2", bus.capture_state);
      else n_pass++;
   endtask

   task automatic test_trigger();
      do_reset();
      strobe(16'hFFFB);
      n_total++;
      if ({bus.capture_state, bus.write_enable} !== 3'b000) $display("FAIL trig_neg5: got state %0d we %b want 0 0", bus.capture_state, bus.write_enable);
      else n_pass++;
      strobe(16'h0003);
      n_total++;
      if (bus.capture_state !== 2'd1) $display("FAIL trig_state: got %0d want 1", bus.capture_state);
      else n_pass++;
      n_total++;
      if ({bus.write_enable, bus.write_address, bus.write_sample} !== {1'b1, 9'h100, 8'h80})
         $display("FAIL trig_first_write: got we %b addr %h samp %h want 1 100 80", bus.write_enable, bus.write_address, bus.write_sample);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({bus.write_enable, bus.write_address} !== {1'b0, 9'h100}) $display("FAIL trig_we_pulse: got we %b addr %h want 0 100", bus.write_enable, bus.write_address);
      else n_pass++;
   endtask

   task automatic test_capture();
      do_reset();
      capture_ramp(9'h100, 16'hFF00);
      strobe(16'h1234);
      n_total++;
      if ({bus.write_enable, bus.write_address, bus.capture_state} !== {1'b0, 9'h1FF, 2'd2})
         $display("FAIL cap_strobe257: got we %b addr %h state %0d want 0 1ff 2", bus.write_enable, bus.write_address, bus.capture_state);
      else n_pass++;
   endtask

   task automatic test_flip();
      repeat (50) @(negedge clk);
      n_total++;
      if ({bus.read_index, bus.capture_state} !== {1'b0, 2'd2}) $display("FAIL flip_hold: got ri %b state %0d want 0 2", bus.read_index, bus.capture_state);
      else n_pass++;
      bus.wave_display_idle = 1'b1;
      @(negedge clk);
      bus.wave_display_idle = 1'b0;
      n_total++;
      if ({bus.read_index, bus.capture_state} !== {1'b1, 2'd0}) $display("FAIL flip_toggle: got ri %b state %0d want 1 0", bus.read_index, bus.capture_state);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (bus.read_index !== 1'b1) $display("FAIL flip_once: got ri %b want 1", bus.read_index);
      else n_pass++;
      capture_ramp(9'h000, 16'h8000);
   endtask

   task automatic test_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_total++;
      if ({bus.capture_state, bus.read_index, bus.write_enable, bus.write_address, bus.write_sample} !== 21'd0)
         $display("FAIL reset_outputs: got state %0d ri %b we %b addr %h samp %h want all 0", bus.capture_state, bus.read_index, bus.write_enable, bus.write_address, bus.write_sample);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int nw;
      nw = 0;
      do_reset();
      for (int i = 0; i <= 1280; i++) begin
         @(negedge clk);
         if (bus.write_enable) nw++;
         if (i == 1023) begin
            n_total++;
            if ({bus.write_enable, bus.capture_state} !== 3'b000) $display("FAIL tmo_strobe1023: got we %b state %0d want 0 0", bus.write_enable, bus.capture_state);
            else n_pass++;
         end
         if (i == 1024) begin
            n_total++;
            if ({bus.write_enable, bus.write_address, bus.write_sample, bus.capture_state} !== {1'b1, 9'h100, 8'h80, 2'd1})
               $display("FAIL tmo_start: got we %b addr %h samp %h state %0d want 1 100 80 1", bus.write_enable, bus.write_address, bus.write_sample, bus.capture_state);
            else n_pass++;
         end
         bus.new_sample_ready = (i < 1280);
         bus.new_sample_in = 16'd100;
      end
      n_total++;
      if (nw !== 256) $display("FAIL tmo_writes: got %0d want 256", nw);
      else n_pass++;
      n_total++;
      if ({bus.write_address, bus.capture_state} !== {9'h1FF, 2'd2}) $display("FAIL tmo_end: got addr %h state %0d want 1ff 2", bus.write_address, bus.capture_state);
      else n_pass++;
   endtask

   task automatic test_idle_held();
      int bad;
      bad = 0;
      do_reset();
      bus.wave_display_idle = 1'b1;
      strobe(16'hFFFF);
      strobe(16'h0001);
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         if (bus.read_index !== 1'b0) bad++;
         bus.new_sample_ready = 1'b1;
         bus.new_sample_in = 16'h0001;
      end
      @(negedge clk);
      bus.new_sample_ready = 1'b0;
      n_total++;
      if (bad !== 0) $display("FAIL idle_ri_stable: got %0d flips want 0", bad);
      else n_pass++;
      n_total++;
      if ({bus.read_index, bus.capture_state} !== {1'b0, 2'd2}) $display("FAIL idle_wait: got ri %b state %0d want 0 2", bus.read_index, bus.capture_state);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({bus.read_index, bus.capture_state} !== {1'b1, 2'd0}) $display("FAIL idle_flip: got ri %b state %0d want 1 0", bus.read_index, bus.capture_state);
      else n_pass++;
      repeat (5) @(negedge clk);
      n_total++;
      if (bus.read_index !== 1'b1) $display("FAIL idle_flip_once: got ri %b want 1", bus.read_index);
      else n_pass++;
      bus.wave_display_idle = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      strobe(16'hFFFF);
      strobe(16'h0001);
      for (int i = 0; i < 36; i++) strobe(16'h0001);
      n_total++;
      if ({bus.capture_state, bus.write_address} !== {2'd1, 9'h124}) $display("FAIL mid_count: got state %0d addr %h want 1 124", bus.capture_state, bus.write_address);
      else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_total++;
      if ({bus.capture_state, bus.read_index, bus.write_enable, bus.write_address, bus.write_sample} !== 21'd0)
         $display("FAIL mid_reset: got state %0d ri %b we %b addr %h samp %h want all 0", bus.capture_state, bus.read_index, bus.write_enable, bus.write_address, bus.write_sample);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      strobe(16'hFFFF);
      strobe(16'h0001);
      n_total++;
      if ({bus.write_enable, bus.write_address, bus.write_sample, bus.capture_state} !== {1'b1, 9'h100, 8'h80, 2'd1})
         $display("FAIL mid_restart: got we %b addr %h samp %h state %0d want 1 100 80 1", bus.write_enable, bus.write_address, bus.write_sample, bus.capture_state);
      else n_pass++;
   endtask

   initial begin
      bus.new_sample_ready = 1'b0;
      bus.new_sample_in = '0;
      bus.wave_display_idle = 1'b0;
      test_trigger();
      test_capture();
      test_flip();
      test_reset();
      test_timeout();
      test_idle_held();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/wave_capture_ctrl.md
Name: wave_capture_ctrl

Overview:
- Sequences the double-buffered 512x8 sample RAM shared by audio capture and wave_display.
- Waits for a positive zero crossing in the codec sample stream, or a timeout, then writes 256 consecutive samples into the half not being displayed.
- Waits for the display to go idle (vertical blank), then flips read_index so the display shows the fresh half.
- Sits between the codec/sample pipeline and the sample RAM write port; read_index feeds wave_display.

Parameters:
- SAMPLE_W, 16, width of incoming signed audio samples (two's complement).
- ADDR_W, 8, per-half address width; 2**ADDR_W = 256 samples per capture.
- TRIG_TIMEOUT, 1024, number of accepted samples in ARMED without a trigger before a forced capture.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- new_sample_ready  in  1  one-cycle strobe; new_sample_in is valid this cycle
- new_sample_in  in  SAMPLE_W  signed audio sample
- wave_display_idle  in  1  high while display is outside the visible region (safe to swap buffers)
- write_enable  out  1  sample RAM write strobe
- write_address  out  ADDR_W+1  RAM write address {~read_index, count}
- write_sample  out  8  offset-binary sample {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-8]}
- read_index  out  1  half selected for display
- capture_state  out  2  current state, for debug/LED

Behaviour:
- All outputs registered. Reset (reset=0, asynchronous) forces:
  - state=ARMED, read_index=0, write_enable=0, write_address=0, write_sample=0
  - count=0, prev_sample=0, timeout counter=0
- Samples are accepted only on cycles with new_sample_ready=1. Strobes may arrive back-to-back.
- prev_sample updates on every accepted sample in every state.
- Trigger: prev_sample[MSB]=1 and new_sample_in[MSB]=0, evaluated on the accepted sample.
- ARMED:
  - On trigger: go to ACTIVE. The triggering sample becomes index 0 and is written.
  - Otherwise the timeout counter increments. When it reaches TRIG_TIMEOUT-1 on an accepted sample, that sample starts capture exactly like a trigger.
  - Timeout counter clears on entering ARMED.
- ACTIVE: each accepted sample is written at {~read_index, count}.
  - write_enable pulses high for exactly one cycle, the cycle after the strobe (latency 1).
  - write_address and write_sample are valid in that same cycle and hold until the next write.
  - count increments after each write. The write at count=2**ADDR_W-1 moves state to WAIT and wraps count to 0.
- WAIT: accepted samples are not written.
  - On the first cycle with wave_display_idle=1, toggle read_index and go to ARMED.
  - A flip happens at most once per capture.
- wave_display_idle is ignored in ARMED and ACTIVE, so read_index never changes mid-capture.
- Captured writes never target the displayed half: address MSB is ~read_index throughout ACTIVE.
- Simultaneous trigger and timeout in ARMED: treated as one capture start.
- Reset mid-ACTIVE: capture is aborted and the partially written half is left stale; read_index returns to 0.
- capture_state encoding: ARMED=0, ACTIVE=1, WAIT=2; 3 is unreachable and decodes to ARMED.

Decomposition:
- Package wave_capture_pkg holds:
  - state encodings ARMED/ACTIVE/WAIT
  - default SAMPLE_W, ADDR_W and TRIG_TIMEOUT constants
  - the offset-binary conversion function
- One sub-module, zero_cross_detect:
  - owns prev_sample
  - outputs a one-cycle trigger pulse aligned with new_sample_ready

Test Plan:
- Reset release, then strobes with samples -5, +3 → state ARMED→ACTIVE on the +3 strobe. First write: write_address=9'h100, write_sample=8'h80, write_enable high for 1 cycle the cycle after the strobe.
- Capture 256 strobed samples (ramp 0..255<<8) with read_index=0 → addresses 0x100..0x1FF written in order; state=WAIT after the 256th write; no write on strobe 257.
- In WAIT, hold wave_display_idle=0 for 50 cycles, then pulse it to 1 → read_index 0→1 on the cycle after idle=1; state ARMED. The next capture writes addresses 0x000..0x0FF.
- Constant sample +100 for 1024 strobes in ARMED → forced capture on strobe 1024; first write_sample=8'h80; 256 writes follow.
- wave_display_idle=1 held throughout ARMED and ACTIVE → read_index unchanged until WAIT is reached, then toggles exactly once.
- Drive reset low at capture count=37 → outputs are immediately at reset values. After release with samples -1, +1: capture restarts at address 0x100.
